// File: rtl/peripheral_apb4_arbiter_if.sv
// Requester-side and APB4-side signal bundle for the APB4 arbiter.
interface peripheral_apb4_arbiter_if #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned PADDR_SIZE = 10,
    parameter int unsigned PDATA_SIZE = 8
);
    localparam int unsigned SW = PDATA_SIZE / 8;

    // requester side
    logic [N_REQ-1:0]            req;
    logic [N_REQ*PADDR_SIZE-1:0] req_addr;
    logic [N_REQ-1:0]            req_write;
    logic [N_REQ*PDATA_SIZE-1:0] req_wdata;
    logic [N_REQ*SW-1:0]         req_strb;
    logic [N_REQ*3-1:0]          req_prot;
    logic [N_REQ-1:0]            ack;
    logic [PDATA_SIZE-1:0]       rdata;
    logic                        err;

    // APB4 side
    logic                        PSEL;
    logic                        PENABLE;
    logic                        PWRITE;
    logic [PADDR_SIZE-1:0]       PADDR;
    logic [PDATA_SIZE-1:0]       PWDATA;
    logic [SW-1:0]               PSTRB;
    logic [2:0]                  PPROT;
    logic [PDATA_SIZE-1:0]       PRDATA;
    logic                        PREADY;
    logic                        PSLVERR;

    // arbiter view: serves requesters, masters the APB bus
    modport master (
        input  req, req_addr, req_write, req_wdata, req_strb, req_prot,
        output ack, rdata, err,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        input  PRDATA, PREADY, PSLVERR
    );

    // environment view: requesters plus APB completer
    modport slave (
        output req, req_addr, req_write, req_wdata, req_strb, req_prot,
        input  ack, rdata, err,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/peripheral_apb4_arbiter.sv
// Round-robin arbiter funnelling N_REQ requesters onto one APB4 master port.
module peripheral_apb4_arbiter #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned PADDR_SIZE = 10,
    parameter int unsigned PDATA_SIZE = 8,
    parameter int unsigned TIMEOUT    = 255
) (
    input logic                     PCLK,
    input logic                     PRESETn,
    peripheral_apb4_arbiter_if.master bus
);
    localparam int unsigned GW = $clog2(N_REQ);
    localparam int unsigned SW = PDATA_SIZE / 8;
    // the completing no-PREADY cycle is the one whose increment would reach TIMEOUT
    localparam logic [7:0]  TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

    state_e                 state_q, state_d;
    logic                   psel_q, psel_d;
    logic                   penable_q, penable_d;
    logic                   pwrite_q, pwrite_d;
    logic [PADDR_SIZE-1:0]  paddr_q, paddr_d;
    logic [PDATA_SIZE-1:0]  pwdata_q, pwdata_d;
    logic [SW-1:0]          pstrb_q, pstrb_d;
    logic [2:0]             pprot_q, pprot_d;
    logic [N_REQ-1:0]       ack_q, ack_d;
    logic [PDATA_SIZE-1:0]  rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [GW-1:0]          last_q, last_d;
    logic [GW-1:0]          grant_q, grant_d;

    logic [PADDR_SIZE-1:0]  addr_a  [N_REQ];
    logic [PDATA_SIZE-1:0]  wdata_a [N_REQ];
    logic [SW-1:0]          strb_a  [N_REQ];
    logic [2:0]             prot_a  [N_REQ];
    logic [N_REQ-1:0]       elig_c;
    logic                   found_c;
    logic [GW-1:0]          pick_c;

    // unpack per-requester slices
    for (genvar g = 0; g < int'(N_REQ); g++) begin : g_slice
        assign addr_a[g]  = bus.req_addr[g*PADDR_SIZE +: PADDR_SIZE];
        assign wdata_a[g] = bus.req_wdata[g*PDATA_SIZE +: PDATA_SIZE];
        assign strb_a[g]  = bus.req_strb[g*SW +: SW];
        assign prot_a[g]  = bus.req_prot[g*3 +: 3];
    end

    // a requester being acked this cycle may not be re-granted
    assign elig_c = bus.req & ~ack_q;

    // round-robin search starting just after the last completed grant
    always_comb begin
        int unsigned idx;
        found_c = 1'b0;
        pick_c  = '0;
        idx     = 0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            idx = 32'(last_q) + off;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found_c && elig_c[GW'(idx)]) begin
                found_c = 1'b1;
                pick_c  = GW'(idx);
            end
        end
    end

    // next-state and output logic
    always_comb begin
        logic done;
        state_d   = state_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        pprot_d   = pprot_q;
        ack_d     = '0;
        rdata_d   = '0;
        err_d     = 1'b0;
        cnt_d     = cnt_q;
        last_d    = last_q;
        grant_d   = grant_q;
        done      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found_c) begin
                    grant_d   = pick_c;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = bus.req_write[pick_c];
                    paddr_d   = addr_a[pick_c];
                    pwdata_d  = wdata_a[pick_c];
                    pstrb_d   = bus.req_write[pick_c] ? strb_a[pick_c] : '0;
                    pprot_d   = prot_a[pick_c];
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    done    = 1'b1;
                    rdata_d = pwrite_q ? '0 : bus.PRDATA;
                    err_d   = bus.PSLVERR;
                end else if (cnt_q == TO_LAST) begin
                    done    = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (done) begin
            ack_d     = N_REQ'(1) << grant_q;
            psel_d    = 1'b0;
            penable_d = 1'b0;
            last_d    = grant_q;
            state_d   = IDLE;
        end
    end

    // state register; reset aborts any transfer without ack
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            pprot_q   <= '0;
            ack_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            last_q    <= GW'(N_REQ - 1);
            grant_q   <= '0;
        end else begin
            state_q   <= state_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            pprot_q   <= pprot_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
        end
    end

    assign bus.PSEL    = psel_q;
    assign bus.PENABLE = penable_q;
    assign bus.PWRITE  = pwrite_q;
    assign bus.PADDR   = paddr_q;
    assign bus.PWDATA  = pwdata_q;
    assign bus.PSTRB   = pstrb_q;
    assign bus.PPROT   = pprot_q;
    assign bus.ack     = ack_q;
    assign bus.rdata   = rdata_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_peripheral_apb4_arbiter.sv
// Directed self-checking bench for peripheral_apb4_arbiter.
module tb_peripheral_apb4_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned PA = 10;
    localparam int unsigned PD = 8;

    logic PCLK;
    logic PRESETn;
    int   n_checks;
    int   n_fail;
    logic [PA-1:0] exp_addr [4];

    peripheral_apb4_arbiter_if #(.N_REQ(N), .PADDR_SIZE(PA), .PDATA_SIZE(PD)) bus ();
    peripheral_apb4_arbiter_if #(.N_REQ(N), .PADDR_SIZE(PA), .PDATA_SIZE(PD)) bus_to ();

    peripheral_apb4_arbiter #(.N_REQ(N), .PADDR_SIZE(PA), .PDATA_SIZE(PD), .TIMEOUT(255)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    peripheral_apb4_arbiter #(.N_REQ(N), .PADDR_SIZE(PA), .PDATA_SIZE(PD), .TIMEOUT(4)) dut_to (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus_to)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        PRESETn  = 1'b0;
        bus.req = '0;   bus.req_addr = '0;  bus.req_write = '0;
        bus.req_wdata = '0; bus.req_strb = '0; bus.req_prot = '0;
        bus.PRDATA = '0; bus.PREADY = 1'b1; bus.PSLVERR = 1'b0;
        bus_to.req = '0;   bus_to.req_addr = '0;  bus_to.req_write = '0;
        bus_to.req_wdata = '0; bus_to.req_strb = '0; bus_to.req_prot = '0;
        bus_to.PRDATA = '0; bus_to.PREADY = 1'b0; bus_to.PSLVERR = 1'b0;

        // reset state
        #12;
        check("rst_psel",    32'(bus.PSEL), 32'h0);
        check("rst_penable", 32'(bus.PENABLE), 32'h0);
        check("rst_pwrite",  32'(bus.PWRITE), 32'h0);
        check("rst_paddr",   32'(bus.PADDR), 32'h0);
        check("rst_pwdata",  32'(bus.PWDATA), 32'h0);
        check("rst_pstrb",   32'(bus.PSTRB), 32'h0);
        check("rst_pprot",   32'(bus.PPROT), 32'h0);
        check("rst_ack",     32'(bus.ack), 32'h0);
        check("rst_rdata",   32'(bus.rdata), 32'h0);
        check("rst_err",     32'(bus.err), 32'h0);
        #10;
        PRESETn = 1'b1;
        tick();

        // single write from requester 2, req held one cycle past its ack
        bus.req_addr[2*PA +: PA]  = 10'h055;
        bus.req_wdata[2*PD +: PD] = 8'hA5;
        bus.req_strb[2]           = 1'b1;
        bus.req_prot[2*3 +: 3]    = 3'b101;
        bus.req_write[2]          = 1'b1;
        bus.PRDATA                = 8'hFF;
        bus.req[2]                = 1'b1;
        tick();
        check("wr_psel",    32'(bus.PSEL), 32'h1);
        check("wr_penable", 32'(bus.PENABLE), 32'h0);
        check("wr_pwrite",  32'(bus.PWRITE), 32'h1);
        check("wr_paddr",   32'(bus.PADDR), 32'h055);
        check("wr_pwdata",  32'(bus.PWDATA), 32'hA5);
        check("wr_pstrb",   32'(bus.PSTRB), 32'h1);
        check("wr_pprot",   32'(bus.PPROT), 32'h5);
        tick();
        check("wr_setup_penable", 32'(bus.PENABLE), 32'h1);
        check("wr_setup_ack",     32'(bus.ack), 32'h0);
        tick();
        check("wr_ack",     32'(bus.ack), 32'h4);
        check("wr_err",     32'(bus.err), 32'h0);
        check("wr_rdata",   32'(bus.rdata), 32'h0);
        check("wr_psel_done", 32'(bus.PSEL), 32'h0);
        tick();
        check("wr_no_regrant", 32'(bus.PSEL), 32'h0);
        check("wr_ack_clr",    32'(bus.ack), 32'h0);
        bus.req[2] = 1'b0;
        tick();
        check("wr_idle", 32'(bus.PSEL), 32'h0);

        // read from requester 1 with five wait states and a slave error
        bus.req_addr[1*PA +: PA] = 10'h1AB;
        bus.req_strb[1]          = 1'b1;
        bus.req_write[1]         = 1'b0;
        bus.PREADY               = 1'b0;
        bus.PRDATA               = 8'h3C;
        bus.req[1]               = 1'b1;
        tick();
        check("rd_psel",   32'(bus.PSEL), 32'h1);
        check("rd_pwrite", 32'(bus.PWRITE), 32'h0);
        check("rd_pstrb",  32'(bus.PSTRB), 32'h0);
        tick();
        for (int w = 0; w < 5; w++) begin
            tick();
            check("rd_wait_ack",   32'(bus.ack), 32'h0);
            check("rd_wait_paddr", 32'(bus.PADDR), 32'h1AB);
        end
        bus.PREADY  = 1'b1;
        bus.PSLVERR = 1'b1;
        tick();
        check("rd_ack",   32'(bus.ack), 32'h2);
        check("rd_rdata", 32'(bus.rdata), 32'h3C);
        check("rd_err",   32'(bus.err), 32'h1);
        bus.req[1]  = 1'b0;
        bus.PSLVERR = 1'b0;
        tick();
        check("rd_ack_clr",   32'(bus.ack), 32'h0);
        check("rd_rdata_clr", 32'(bus.rdata), 32'h0);
        check("rd_err_clr",   32'(bus.err), 32'h0);

        // contention after reset: round-robin from requester 0
        PRESETn = 1'b0;
        #3;
        PRESETn = 1'b1;
        exp_addr[0] = 10'h100; exp_addr[1] = 10'h111;
        exp_addr[2] = 10'h122; exp_addr[3] = 10'h133;
        bus.req_addr[0*PA +: PA] = 10'h100;
        bus.req_addr[1*PA +: PA] = 10'h111;
        bus.req_addr[2*PA +: PA] = 10'h122;
        bus.req_addr[3*PA +: PA] = 10'h133;
        bus.req_write = 4'b1111;
        bus.req       = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rr_psel",  32'(bus.PSEL), 32'h1);
            check("rr_paddr", 32'(bus.PADDR), 32'(exp_addr[k]));
            tick();
            tick();
            check("rr_ack",      32'(bus.ack), 32'(4'(1) << k));
            check("rr_idle_gap", 32'(bus.PSEL), 32'h0);
            bus.req = bus.req & ~(4'(1) << k);
        end
        tick();
        check("rr_drained", 32'(bus.PSEL), 32'h0);

        // timeout instance: PREADY stuck low
        bus_to.req_addr[3*PA +: PA] = 10'h3FF;
        bus_to.PRDATA               = 8'h77;
        bus_to.req[3]               = 1'b1;
        tick();
        check("to_psel", 32'(bus_to.PSEL), 32'h1);
        tick();
        check("to_penable", 32'(bus_to.PENABLE), 32'h1);
        for (int w = 0; w < 3; w++) begin
            tick();
            check("to_wait_ack", 32'(bus_to.ack), 32'h0);
        end
        tick();
        check("to_ack",   32'(bus_to.ack), 32'h8);
        check("to_err",   32'(bus_to.err), 32'h1);
        check("to_rdata", 32'(bus_to.rdata), 32'h0);
        bus_to.req[3] = 1'b0;
        tick();
        check("to_psel_after", 32'(bus_to.PSEL), 32'h0);
        check("to_ack_clr",    32'(bus_to.ack), 32'h0);

        // reset in the middle of an ACCESS phase
        bus.PREADY               = 1'b0;
        bus.req_addr[2*PA +: PA] = 10'h222;
        bus.req                  = 4'b0100;
        tick();
        tick();
        tick();
        check("mr_in_access", 32'(bus.PENABLE), 32'h1);
        #2;
        PRESETn = 1'b0;
        #1;
        check("mr_psel",    32'(bus.PSEL), 32'h0);
        check("mr_penable", 32'(bus.PENABLE), 32'h0);
        check("mr_ack",     32'(bus.ack), 32'h0);
        bus.req_addr[0*PA +: PA] = 10'h0A0;
        bus.req_addr[3*PA +: PA] = 10'h3A3;
        bus.req    = 4'b1001;
        bus.PREADY = 1'b1;
        #2;
        PRESETn = 1'b1;
        tick();
        check("mr_grant0_psel",  32'(bus.PSEL), 32'h1);
        check("mr_grant0_paddr", 32'(bus.PADDR), 32'h0A0);
        tick();
        tick();
        check("mr_ack0", 32'(bus.ack), 32'h1);
        bus.req = 4'b1000;
        tick();
        check("mr_grant3_paddr", 32'(bus.PADDR), 32'h3A3);
        tick();
        tick();
        check("mr_ack3", 32'(bus.ack), 32'h8);
        bus.req = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
